bus_demultiplex: RTL and testbench
==================================

# bus_demultiplex

Registered 1-to-4 bus demultiplexer: the distribution side of the 4:1 `bus_multiplex`. It accepts 8-bit words on a single valid/ready input stream, each tagged with a 2-bit destination select. It steers each word into one of four output channels A/B/C/D, and each channel has a one-entry holding register and its own valid/ready handshake. It sits where a shared bus fans out to four independent consumers that may stall separately.

## Interface
- `WIDTH`, 8, data width of input and every output channel

- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `IN_DATA`  input  WIDTH  word to deliver
- `IN_SEL`  input  2  destination: 0=A, 1=B, 2=C, 3=D
- `IN_VALID`  input  1  IN_DATA/IN_SEL valid
- `IN_READY`  output  1  block can accept the presented word this cycle
- `OUTA`, `OUTB`, `OUTC`, `OUTD`  output  WIDTH  holding-register contents, one per channel
- `OUT_VALID`  output  4  bit i: channel i holds an undelivered word (bit0=A … bit3=D)
- `OUT_READY`  input  4  bit i: consumer i takes the word this cycle
- `XFER_CNT`  output  8  accepted-word counter (present only with `BUS_DEMUX_CNT_EN`)

## Operation
- Each channel i has a data register `OUTx` and a full flag, which drives `OUT_VALID[i]`.
- Input accept: `acc = IN_VALID & IN_READY`.
- `IN_READY = ~OUT_VALID[IN_SEL] | OUT_READY[IN_SEL]`. This is combinational on `IN_SEL` and `OUT_READY`.
  - Full throughput to one channel is possible when its consumer is always ready.
- Output drain on channel i: `drn[i] = OUT_VALID[i] & OUT_READY[i]`.
- Per-channel next state, evaluated in this priority order:
  - acc targets i: `OUTx <= IN_DATA`, `OUT_VALID[i] <= 1`. This applies whether or not channel i also drains in the same cycle; the new word replaces the drained one.
  - else drn[i]: `OUT_VALID[i] <= 0`, and `OUTx` holds its stale value.
  - else: hold.
- Only the selected channel is loaded. Other channels drain independently in the same cycle.
- Channels never reorder or drop words. Words sent to the same channel are delivered in acceptance order.
- `OUTx` values are only meaningful while `OUT_VALID[i]=1`.
- `IN_SEL` and `IN_DATA` are ignored when `IN_VALID=0`. `IN_READY` is still driven from `IN_SEL` in that case.
- Upstream rule: once `IN_VALID` is asserted, data and select must hold until accepted.
- Downstream rule: `OUTx` and `OUT_VALID[i]` are stable while `OUT_VALID[i]=1 & OUT_READY[i]=0`.

## Timing
- Reset (async assert, released synchronously by the integrator):
  - `OUTA..OUTD = 0`, `OUT_VALID = 4'b0000`.
  - `XFER_CNT = 0`.
  - `IN_READY = 1`, since all channels are empty.
- Latency: a word accepted at edge N appears with `OUT_VALID[i]=1` immediately after edge N. It is consumable in the cycle following acceptance.
- Throughput: 1 word/cycle when the destination consumer is ready, or when consecutive words target different empty channels.
- Channel full and its consumer not ready: `IN_READY=0` only while `IN_SEL` points at that channel. Words to other channels are still accepted.
- Simultaneous load and drain on the same channel: the old word is delivered, the new word is registered, and `OUT_VALID` stays 1.
- Reset asserted mid-operation: all held words are discarded immediately (asynchronously) and all outputs return to their reset values. No partial handshake survives reset.

## Configuration
- `BUS_DEMUX_CNT_EN` defined:
  - Port `XFER_CNT[7:0]` exists.
  - It increments by 1 on every `acc` cycle, wraps 255→0, and resets to 0.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset: assert `reset` with arbitrary inputs → `OUT_VALID=0000`, all `OUTx=0`, `IN_READY=1`, `XFER_CNT=0`.
- Basic routing, with `OUT_READY=1111`:
  - Send 0x00→sel0, 0x0F→sel3, 0xF0→sel2, 0xFF→sel1 on consecutive cycles.
  - Each appears on A/D/C/B respectively one edge after acceptance, with only that `OUT_VALID` bit set.
- Backpressure, with `OUT_READY[1]=0`:
  - Send 0x11 to B, then 0x22 to B → 0x11 held on `OUTB`, `IN_READY=0` for the second word.
  - Release `OUT_READY[1]` → 0x11 delivered and 0x22 accepted the same cycle, with `OUT_VALID[1]` staying 1.
- Independence: with channel B stalled full, send 0x33 to A, 0x44 to C → both accepted back-to-back, and B holds 0x11 unchanged.
- Mid-operation reset: with all four channels full, assert `reset` asynchronously → `OUT_VALID` drops to 0000 before the next clock edge.
- With `BUS_DEMUX_CNT_EN`: accept 258 words → `XFER_CNT=2`, and it does not increment on cycles where `IN_VALID=1, IN_READY=0`.

Source files
------------

// File: rtl/bus_demultiplex.sv
// ----------------------------------------------------------------------------
// bus_demultiplex
//
// Registered 1-to-4 bus demultiplexer. Words arrive on one valid/ready input
// stream, each tagged with a 2-bit destination select. Each word is steered
// into one of four output channels (A/B/C/D). Every channel has a one-entry
// holding register and its own valid/ready handshake, so the four consumers
// can stall independently of each other.
//
// Optional feature macro: BUS_DEMUX_CNT_EN
//   When defined, the XFER_CNT port and an 8-bit accepted-word counter exist.
//   When it is not defined, the port and the counter are absent and all other
//   behaviour is identical.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   IN_DATA    in   WIDTH  word to deliver
//   IN_SEL     in   2      destination: 0=A, 1=B, 2=C, 3=D
//   IN_VALID   in   1      IN_DATA/IN_SEL valid
//   IN_READY   out  1      the presented word can be accepted this cycle
//   OUTA..OUTD out  WIDTH  holding-register contents, one per channel
//   OUT_VALID  out  4      bit i: channel i holds an undelivered word
//   OUT_READY  in   4      bit i: consumer i takes its word this cycle
//   XFER_CNT   out  8      accepted-word counter (BUS_DEMUX_CNT_EN only)
//
// Handshake semantics, on both the input side and every output channel:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Once valid is raised, the producer holds data (and select) stable until
//   the transfer happens. Ready may depend combinationally on the other
//   side's signals. Valid never depends on ready.
// ----------------------------------------------------------------------------
module bus_demultiplex #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [1:0]       IN_SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUTA,
    output logic [WIDTH-1:0] OUTB,
    output logic [WIDTH-1:0] OUTC,
    output logic [WIDTH-1:0] OUTD,
    output logic [3:0]       OUT_VALID,
    input  logic [3:0]       OUT_READY
`ifdef BUS_DEMUX_CNT_EN
    ,
    output logic [7:0]       XFER_CNT
`endif
);

    // Per-channel holding registers and full flags.
    logic [3:0][WIDTH-1:0] data_q;
    logic [3:0]            full_q;

    // Handshake terms.
    logic       acc;
    logic [3:0] load;
    logic [3:0] drn;

    // The input can be accepted if the selected channel is empty, or if its
    // consumer takes the held word in this same cycle. This makes full
    // throughput into a single always-ready channel possible. IN_READY is
    // driven from IN_SEL even while IN_VALID is low.
    assign IN_READY = ~full_q[IN_SEL] | OUT_READY[IN_SEL];
    assign acc      = IN_VALID & IN_READY;

    // One-hot load strobe. Only the selected channel is written.
    assign load = acc ? (4'b0001 << IN_SEL) : 4'b0000;

    // A channel drains whenever its held word is taken by the consumer.
    assign drn = full_q & OUT_READY;

    // Channel state. A load has priority over a drain: on a simultaneous load
    // and drain, the old word goes out and the new word replaces it, so the
    // full flag stays set. A drain alone clears the flag and leaves the stale
    // data in place, because data is only meaningful while the flag is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 4'b0000;
            data_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= IN_DATA;
                    full_q[i] <= 1'b1;
                end else if (drn[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign OUTA      = data_q[0];
    assign OUTB      = data_q[1];
    assign OUTC      = data_q[2];
    assign OUTD      = data_q[3];
    assign OUT_VALID = full_q;

`ifdef BUS_DEMUX_CNT_EN
    // Counts accepted words. It wraps naturally from 255 to 0.
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (acc) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign XFER_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_bus_demultiplex.sv
module tb_bus_demultiplex;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outa;
    logic [WIDTH-1:0] outb;
    logic [WIDTH-1:0] outc;
    logic [WIDTH-1:0] outd;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
`ifdef BUS_DEMUX_CNT_EN
    logic [7:0]       xfer_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Clock / reset block: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_demultiplex #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .IN_DATA   (in_data),
        .IN_SEL    (in_sel),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUTA      (outa),
        .OUTB      (outb),
        .OUTC      (outc),
        .OUTD      (outd),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
`ifdef BUS_DEMUX_CNT_EN
        ,
        .XFER_CNT  (xfer_cnt)
`endif
    );

    // Advance to 1 ns after the next rising edge. Inputs are driven and
    // outputs are sampled there, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Arbitrary inputs while reset is held.
        drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        out_ready = 4'($urandom_range(0, 15));
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0000", out_valid);
        end
        checks++;
        if ({outa, outb, outc, outd} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00000000", {outa, outb, outc, outd});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
`ifdef BUS_DEMUX_CNT_EN
        checks++;
        if (xfer_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt);
        end
`endif
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 4'b0000;
        reset = 1'b0;
        step();
    endtask

    task automatic test_routing();
        logic [1:0] sel_t [4];
        logic [7:0] dat_t [4];
        logic [3:0] exp_v;
        logic [7:0] got;
        sel_t = '{2'd0, 2'd3, 2'd2, 2'd1};
        dat_t = '{8'h00, 8'h0F, 8'hF0, 8'hFF};
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, sel_t[k], dat_t[k]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL route_ready[%0d]: got %b expected 1", k, in_ready);
            end
            step();
            // The previous word drained at this edge, so only the new bit is set.
            exp_v = 4'b0001 << sel_t[k];
            case (sel_t[k])
                2'd0: got = outa;
                2'd1: got = outb;
                2'd2: got = outc;
                default: got = outd;
            endcase
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL route_valid[%0d]: got %b expected %b", k, out_valid, exp_v);
            end
            checks++;
            if (got !== dat_t[k]) begin
                errors++;
                $display("FAIL route_data[%0d]: got %h expected %h", k, got, dat_t[k]);
            end
        end
        drive(1'b0, 2'd0, 8'h00);
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL route_drained: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_ignored_when_invalid();
        out_ready = 4'b0000;
        drive(1'b0, 2'd2, 8'h5A);
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL idle_no_load: got %b expected 0000", out_valid);
        end
    endtask

    // Backpressure on B combined with independent traffic to A and C.
    task automatic test_backpressure();
        out_ready = 4'b0000;
        drive(1'b1, 2'd1, 8'h11);
        step();
        checks++;
        if (out_valid !== 4'b0010 || outb !== 8'h11) begin
            errors++;
            $display("FAIL bp_first: got valid=%b b=%h expected valid=0010 b=11", out_valid, outb);
        end
        // B stalled and full: words to A and C still go through back-to-back.
        drive(1'b1, 2'd0, 8'h33);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL indep_ready_a: got %b expected 1", in_ready);
        end
        step();
        drive(1'b1, 2'd2, 8'h44);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL indep_ready_c: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 4'b0111 || outa !== 8'h33 || outc !== 8'h44 || outb !== 8'h11) begin
            errors++;
            $display("FAIL indep_state: got valid=%b a=%h b=%h c=%h expected valid=0111 a=33 b=11 c=44",
                     out_valid, outa, outb, outc);
        end
        // IN_READY still follows IN_SEL while IN_VALID is low.
        drive(1'b0, 2'd1, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_follows_sel: got %b expected 0", in_ready);
        end
        // Second word to stalled B is refused and held upstream.
        drive(1'b1, 2'd1, 8'h22);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: got %b expected 0", in_ready);
        end
        step();
        checks++;
        if (outb !== 8'h11 || out_valid !== 4'b0111) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b b=%h expected valid=0111 b=11", out_valid, outb);
        end
        // Release B: old word delivered and new one accepted on the same edge.
        out_ready = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if (outb !== 8'h22 || out_valid !== 4'b0111) begin
            errors++;
            $display("FAIL bp_swap: got valid=%b b=%h expected valid=0111 b=22", out_valid, outb);
        end
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 4'b1111;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_drain_all: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 8'hA0 + 8'(k));
            step();
        end
        drive(1'b0, 2'd0, 8'h00);
        checks++;
        if (out_valid !== 4'b1111 || outd !== 8'hA3) begin
            errors++;
            $display("FAIL full_before_reset: got valid=%b d=%h expected valid=1111 d=a3", out_valid, outd);
        end
        // Assert reset mid-cycle and sample before the next rising edge.
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || {outa, outb, outc, outd} !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h ready=%b expected valid=0000 data=0 ready=1",
                     out_valid, {outa, outb, outc, outd}, in_ready);
        end
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef BUS_DEMUX_CNT_EN
    task automatic test_counter();
        do_reset();
        out_ready = 4'b1111;
        for (int k = 0; k < 258; k++) begin
            drive(1'b1, 2'(k % 4), 8'(k));
            step();
        end
        drive(1'b0, 2'd0, 8'h00);
        step();
        checks++;
        if (xfer_cnt !== 8'd2) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d expected 2", xfer_cnt);
        end
        // Fill A with its consumer stalled, then hold a refused word.
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 8'h77);
        step();
        drive(1'b1, 2'd0, 8'h78);
        step();
        step();
        step();
        checks++;
        if (xfer_cnt !== 8'd3) begin
            errors++;
            $display("FAIL cnt_stall: got %0d expected 3", xfer_cnt);
        end
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 4'b1111;
        step();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        #2;
        test_reset();
        test_routing();
        test_ignored_when_invalid();
        test_backpressure();
        test_mid_reset();
`ifdef BUS_DEMUX_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
